// File: rtl/measure_expectation_2qb_pkg.sv
// Shared constants, FSM state type and clamp helpers for the 2-qubit readout stage.
// Pure definitions: no logic, no latency, no flow control.
package qvc_pkg;

    localparam int FRAC      = 14;
    localparam int ONE       = 1 << FRAC;
    localparam int NUM_AMP   = 4;
    localparam int NUM_WORDS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQR  = 2'd1,
        FIN  = 2'd2
    } meas_state_t;

    // Clamp to [0, 2^(n-1)-1]
    function automatic int sat_u(input int v, input int n);
        int hi;
        hi = (1 << (n - 1)) - 1;
        if (v < 0)
            return 0;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

    // Clamp to [-2^(n-1), 2^(n-1)-1]
    function automatic int sat_s(input int v, input int n);
        int hi;
        int lo;
        hi = (1 << (n - 1)) - 1;
        lo = -(1 << (n - 1));
        if (v < lo)
            return lo;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

endpackage

// File: rtl/measure_expectation_2qb_if.sv
// Start/state-vector request and observable results of the readout stage.
// Plain start/busy/done handshake; no queueing, start is dropped while busy.
interface measure_expectation_2qb_if #(
    parameter int N = 16
);
    logic                start;
    logic signed [N-1:0] psi_in [0:7];
    logic                busy;
    logic                done;
    logic        [N-1:0] prob [0:3];
    logic signed [N-1:0] expz0;
    logic signed [N-1:0] expz1;
    logic        [N-1:0] norm;

    modport master (
        output start, psi_in,
        input  busy, done, prob, expz0, expz1, norm
    );

    modport slave (
        input  start, psi_in,
        output busy, done, prob, expz0, expz1, norm
    );
endinterface

// File: rtl/measure_expectation_2qb_fx_square.sv
// Combinational signed fixed-point square, truncated by >>> FRAC to 2N-FRAC bits.
// Zero latency; no flow control.
module fx_square #(
    parameter int N    = 16,
    parameter int FRAC = 14
) (
    input  logic signed [N-1:0]        w,
    output logic signed [2*N-FRAC-1:0] sq
);
    logic signed [2*N-1:0] prod;

    assign prod = w * w;
    assign sq   = prod[2*N-1:FRAC];
endmodule

// File: rtl/measure_expectation_2qb.sv
// Readout stage: squares the captured state vector one word per cycle, then forms p_k, <Z0>, <Z1>, norm.
// Latency start->done 9 cycles; start ignored while busy, results held until the next completion.
module measure_expectation_2qb
    import qvc_pkg::*;
#(
    parameter int N    = 16,
    parameter int FRAC = qvc_pkg::FRAC
) (
    input  logic                     clk,
    input  logic                     rst,
    measure_expectation_2qb_if.slave io
);
    localparam int SQ_W  = 2 * N - FRAC;
    localparam int ACC_W = SQ_W + 2;
    localparam int EXP_W = ACC_W + 2;

    meas_state_t             state, state_nxt;
    logic [2:0]              idx;
    logic signed [N-1:0]     psi_q [0:NUM_WORDS-1];
    logic signed [ACC_W-1:0] acc   [0:NUM_AMP-1];
    logic signed [SQ_W-1:0]  sq;
    logic signed [EXP_W-1:0] ez0, ez1, nrm;

    fx_square #(.N(N), .FRAC(FRAC)) u_sq (
        .w  (psi_q[idx]),
        .sq (sq)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (io.start) state_nxt = SQR;
            SQR:     if (idx == 3'd7) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign io.busy = (state != IDLE);

    // Observables from the full-width sums so clamping happens only once, at the end
    always_comb begin
        ez0 = EXP_W'(acc[0]) + EXP_W'(acc[1]) - EXP_W'(acc[2]) - EXP_W'(acc[3]);
        ez1 = EXP_W'(acc[0]) - EXP_W'(acc[1]) + EXP_W'(acc[2]) - EXP_W'(acc[3]);
        nrm = EXP_W'(acc[0]) + EXP_W'(acc[1]) + EXP_W'(acc[2]) + EXP_W'(acc[3]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            io.done  <= 1'b0;
            io.expz0 <= '0;
            io.expz1 <= '0;
            io.norm  <= '0;
            for (int k = 0; k < NUM_WORDS; k++) psi_q[k] <= '0;
            for (int k = 0; k < NUM_AMP; k++) begin
                acc[k]     <= '0;
                io.prob[k] <= '0;
            end
        end else begin
            io.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (io.start) begin
                        idx <= '0;
                        for (int k = 0; k < NUM_WORDS; k++) psi_q[k] <= io.psi_in[k];
                        for (int k = 0; k < NUM_AMP; k++) acc[k] <= '0;
                    end
                end
                SQR: begin
                    acc[idx[2:1]] <= acc[idx[2:1]] + ACC_W'(sq);
                    idx           <= idx + 3'd1;
                end
                FIN: begin
                    for (int k = 0; k < NUM_AMP; k++)
                        io.prob[k] <= N'(sat_u(int'(acc[k]), N));
                    io.expz0 <= N'(sat_s(int'(ez0), N));
                    io.expz1 <= N'(sat_s(int'(ez1), N));
                    io.norm  <= N'(sat_u(int'(nrm), N));
                    io.done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_measure_expectation_2qb.sv
// Directed bench for measure_expectation_2qb: cycle-level reference model plus literal result checks.
module tb_measure_expectation_2qb;
    import qvc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    measure_expectation_2qb_if #(.N(16)) io ();

    measure_expectation_2qb #(.N(16), .FRAC(14)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: start accepted when idle, results appear 9 edges later.
    bit     armed = 0;
    bit     pending = 0;
    longint cyc = 0;
    longint due = 0;
    int     cap [8];
    int     m_busy = 0, m_done = 0;
    int     m_prob [4] = '{0, 0, 0, 0};
    int     m_ez0 = 0, m_ez1 = 0, m_norm = 0;

    function automatic int clamp(input longint v, input longint lo, input longint hi);
        if (v < lo) return int'(lo);
        if (v > hi) return int'(hi);
        return int'(v);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            armed   = 1;
            pending = 0;
            m_done  = 0;
            m_prob  = '{0, 0, 0, 0};
            m_ez0   = 0;
            m_ez1   = 0;
            m_norm  = 0;
        end else begin
            m_done = 0;
            if (pending && cyc == due) begin
                longint p [4];
                for (int k = 0; k < 4; k++) begin
                    longint re, im;
                    re   = cap[2*k];
                    im   = cap[2*k+1];
                    p[k] = (re * re) / ONE + (im * im) / ONE;
                    m_prob[k] = clamp(p[k], 0, 32767);
                end
                m_ez0   = clamp(p[0] + p[1] - p[2] - p[3], -32768, 32767);
                m_ez1   = clamp(p[0] - p[1] + p[2] - p[3], -32768, 32767);
                m_norm  = clamp(p[0] + p[1] + p[2] + p[3], 0, 32767);
                m_done  = 1;
                pending = 0;
            end else if (!pending && io.start) begin
                for (int k = 0; k < 8; k++) cap[k] = int'(io.psi_in[k]);
                due     = cyc + 9;
                pending = 1;
            end
        end
        m_busy = pending ? 1 : 0;
        cyc++;
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("busy", longint'(io.busy), m_busy);
            chk("done", longint'(io.done), m_done);
            for (int k = 0; k < 4; k++)
                chk($sformatf("prob%0d", k), longint'(io.prob[k]), m_prob[k]);
            chk("expz0", longint'(io.expz0), m_ez0);
            chk("expz1", longint'(io.expz1), m_ez1);
            chk("norm", longint'(io.norm), m_norm);
        end
    end

    // mode 0 plain, 1 psi change at E+1 and restart at E+3, 2 reset at E+4
    task automatic run(input int v[8], input int mode, input bit now, output int lat, output int bcnt);
        if (!now) @(negedge clk);
        for (int k = 0; k < 8; k++) io.psi_in[k] = 16'(v[k]);
        io.start = 1'b1;
        lat  = 0;
        bcnt = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) io.start = 1'b0;
            if (mode == 1) begin
                if (i == 1) for (int k = 0; k < 8; k++) io.psi_in[k] = 16'sd1234;
                if (i == 3) io.start = 1'b1;
                if (i == 4) io.start = 1'b0;
            end
            if (mode == 2) begin
                if (i == 4) rst = 1'b1;
                if (i == 5) begin
                    rst = 1'b0;
                    chk("abort_busy", longint'(io.busy), 0);
                    chk("abort_prob0", longint'(io.prob[0]), 0);
                    chk("abort_norm", longint'(io.norm), 0);
                end
            end
            if (io.busy) bcnt++;
            if (io.done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic lit(input string tag, input int p0, input int p1, input int p2, input int p3,
                       input int e0, input int e1, input int nm);
        chk({tag, "_prob0"}, longint'(io.prob[0]), p0);
        chk({tag, "_prob1"}, longint'(io.prob[1]), p1);
        chk({tag, "_prob2"}, longint'(io.prob[2]), p2);
        chk({tag, "_prob3"}, longint'(io.prob[3]), p3);
        chk({tag, "_expz0"}, longint'(io.expz0), e0);
        chk({tag, "_expz1"}, longint'(io.expz1), e1);
        chk({tag, "_norm"}, longint'(io.norm), nm);
    endtask

    initial begin
        int lat, bcnt;
        int v00 [8]  = '{16384, 0, 0, 0, 0, 0, 0, 0};
        int vbel [8] = '{11585, 0, 0, 0, 0, 0, 11585, 0};
        int vim [8]  = '{0, 0, 0, -16384, 0, 0, 0, 0};
        int vsat [8] = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
        int v01 [8]  = '{0, 0, 16384, 0, 0, 0, 0, 0};
        int v10 [8]  = '{0, 0, 0, 0, -16384, 0, 0, 0};

        io.start = 1'b0;
        for (int k = 0; k < 8; k++) io.psi_in[k] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        lit("reset", 0, 0, 0, 0, 0, 0, 0);
        chk("reset_busy", longint'(io.busy), 0);
        chk("reset_done", longint'(io.done), 0);

        run(v00, 0, 0, lat, bcnt);
        chk("s1_latency", lat, 10);
        chk("s1_busy_cycles", bcnt, 9);
        lit("s1", 16384, 0, 0, 0, 16384, 16384, 16384);

        repeat (3) @(negedge clk);
        run(vbel, 0, 0, lat, bcnt);
        chk("s2_latency", lat, 10);
        lit("s2", 8191, 0, 0, 8191, 0, 0, 16382);

        run(vim, 0, 0, lat, bcnt);
        chk("s3_latency", lat, 10);
        lit("s3", 0, 16384, 0, 0, 16384, -16384, 16384);

        run(vsat, 0, 0, lat, bcnt);
        chk("s4_latency", lat, 10);
        lit("s4", 32767, 32767, 32767, 32767, 0, 0, 32767);

        run(v01, 1, 0, lat, bcnt);
        chk("s5_latency", lat, 10);
        lit("s5", 0, 16384, 0, 0, 16384, -16384, 16384);
        run(v10, 0, 1, lat, bcnt);
        chk("s5_chain_latency", lat, 10);
        lit("s5_chain", 0, 0, 16384, 0, -16384, 16384, 16384);

        repeat (2) @(negedge clk);
        run(vbel, 2, 0, lat, bcnt);
        chk("s6_no_done", lat, 0);
        lit("s6_abort", 0, 0, 0, 0, 0, 0, 0);
        run(v00, 0, 0, lat, bcnt);
        chk("s6_latency", lat, 10);
        lit("s6", 16384, 0, 0, 0, 16384, 16384, 16384);

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/measure_expectation_2qb.md
Name: measure_expectation_2qb

Overview:
Downstream readout stage for the 2-qubit variational circuit. On a start pulse it captures the final state vector and computes the four basis probabilities, <Z> per qubit, and the total norm. It uses one shared squaring datapath and a small FSM, so the combinational circuit output is reduced to the scalar observables used by the parameter-update loop.

Parameters:
N, 16, word width of every amplitude component and every result (signed two's complement fixed point)
FRAC, 14, fractional bits (Q2.14 at default; 1.0 = 16384)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle request; accepted only when busy=0
psi_in  input  N x [0:7]  state vector; psi_in[2k]=Re(amp k), psi_in[2k+1]=Im(amp k); basis k={q0,q1}, q0 is MSB
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse; results valid from this cycle
prob  output  N x [0:3]  |amp k|^2, unsigned magnitude in Q format, saturated
expz0  output  N  signed <Z> of q0 = p0+p1-p2-p3, saturated
expz1  output  N  signed <Z> of q1 = p0-p1+p2-p3, saturated
norm  output  N  p0+p1+p2+p3, saturated

Behaviour:
- Reset: state=IDLE; busy, done, prob[*], expz0, expz1 and norm all 0; internal accumulators cleared.
- FSM states: IDLE, SQR, FIN.
- IDLE: start=1 registers all 8 psi_in words, clears the accumulators, sets idx=0 and moves to SQR. psi_in is ignored at all other times.
- SQR: one square per cycle over the captured psi word idx (0..7), in order.
  - sq = (w*w) >>> FRAC, truncation, held in 2N-FRAC bits.
  - acc[idx>>1] += sq; accumulators are 2N-FRAC+2 bits wide and never wrap.
  - Leaves for FIN after idx=7 (8 cycles).
- FIN: forms expz0, expz1 and norm from the unsaturated accumulators, then saturates all seven results.
  - prob and norm clamp to [0, 2^(N-1)-1].
  - expz clamps to [-2^(N-1), 2^(N-1)-1].
  - Results are registered to the outputs, done=1 for one cycle, state returns to IDLE.
- Latency: start sampled at edge E; done high during the cycle after edge E+9; busy high for cycles E+1..E+9.
- Outputs hold their last values until the next FIN or reset. They do not change during a later computation.
- start while busy=1 is ignored, with no queueing.
- start in the done cycle is accepted (state is already IDLE).
- rst during SQR or FIN aborts the computation: outputs zeroed, no done pulse.
- No normalisation check. A non-unit input simply yields norm != ONE.

Decomposition:
- Package qvc_pkg holds:
  - FRAC
  - ONE = 1<<FRAC
  - NUM_AMP = 4 and NUM_WORDS = 8 for the 2-qubit case
  - enum meas_state_t {IDLE, SQR, FIN}
  - saturate functions sat_u / sat_s
- One sub-module, fx_square: combinational signed N-bit square with >>>FRAC truncation to 2N-FRAC bits. It is the only multiplier in the block.

Test Plan:
1. |00>, psi_in={16384,0,0,0,0,0,0,0}, start at E -> done at E+9 with prob={16384,0,0,0}, expz0=16384, expz1=16384, norm=16384; busy high for exactly 9 cycles.
2. Bell (|00>+|11>)/sqrt2, psi_in[0]=psi_in[6]=11585, rest 0 -> prob={8191,0,0,8191}, expz0=0, expz1=0, norm=16382.
3. Imaginary and negative input, psi_in[3]=-16384, rest 0 -> prob={0,16384,0,0}, expz0=16384, expz1=-16384, norm=16384.
4. Saturation, all eight words 32767 -> each square 65532 (each internal prob 131064), so prob all 32767, norm 32767, expz0=expz1=0; no wrap to negative.
5. Handshake checks:
   - start pulsed again at E+3 and psi_in changed at E+1 -> both ignored; results match the captured vector.
   - start in the done cycle -> accepted; second done exactly 9 cycles later.
   - Between runs, outputs stay stable until that second done.
6. rst asserted at E+4 during SQR -> next cycle busy=0, all outputs 0, no done. A fresh start then yields the correct scenario-1 results.
